mdu_unit: RTL and testbench

- Multiply/divide unit in the E stage of the 5-stage pipeline, with architectural HI/LO registers.
- It is the responder side of the start/busy handshake that the hazard unit consumes.
- E stage pulses `start` with a MULT/MULTU/DIV/DIVU op; the unit holds `busy` for a fixed latency, then commits HI/LO.
- MFHI/MFLO/MTHI/MTLO access HI/LO directly.

---
 rtl/mdu_unit_if.sv | 21 ++
 rtl/mdu_unit.sv | 167 ++++++++++++++++
 tb/tb_mdu_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_unit_if.sv
// Handshake and HI/LO access bundle between the E stage and mdu_unit.
// With MDU_CANCEL_EN defined, the bundle also carries the pipeline-flush cancel line.
interface mdu_unit_if;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] out;
`ifdef MDU_CANCEL_EN
    logic        cancel;

    modport master (output start, mdu_op, a, b, cancel, input busy, hi, lo, out);
    modport slave  (input start, mdu_op, a, b, cancel, output busy, hi, lo, out);
`else
    modport master (output start, mdu_op, a, b, input busy, hi, lo, out);
    modport slave  (input start, mdu_op, a, b, output busy, hi, lo, out);
`endif
endinterface

// File: rtl/mdu_unit.sv
// Fixed-latency multiply/divide unit with architectural HI/LO registers.
// Optional macro MDU_CANCEL_EN adds a flush cancel that aborts an in-flight operation.
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      rst_n,
    mdu_unit_if.slave bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [7:0] MULT_N   = MULT_CYCLES[7:0];
    localparam logic [7:0] DIV_N    = DIV_CYCLES[7:0];

    logic [7:0]  r_cnt;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_wr;

    logic [7:0]  w_cnt_nx;
    logic [31:0] w_hi_nx;
    logic [31:0] w_lo_nx;
    logic [31:0] w_pend_hi_nx;
    logic [31:0] w_pend_lo_nx;
    logic        w_pend_wr_nx;
    logic [31:0] w_out;
    logic        w_cancel;
    logic        w_launch;
    logic        w_div_zero;
    logic        w_div_ovf;

    logic signed [63:0] w_mul_s;
    logic        [63:0] w_mul_u;
    logic signed [31:0] w_div_b_s;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic        [31:0] w_div_b_u;
    logic        [31:0] w_quo_u;
    logic        [31:0] w_rem_u;

`ifdef MDU_CANCEL_EN
    assign w_cancel = bus.cancel;
`else
    assign w_cancel = 1'b0;
`endif

    assign w_launch = bus.start && !r_busy &&
                      (bus.mdu_op >= OP_MULT) && (bus.mdu_op <= OP_DIVU);

    assign w_mul_s = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    assign w_mul_u = {32'd0, bus.a} * {32'd0, bus.b};

    // A divisor of 1 stands in for zero (result discarded) and for the
    // 0x80000000 / -1 overflow, where dividing by 1 yields exactly the wanted q/r.
    assign w_div_zero = (bus.b == 32'd0);
    assign w_div_ovf  = (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
    assign w_div_b_s  = (w_div_zero || w_div_ovf) ? 32'sd1 : $signed(bus.b);
    assign w_div_b_u  = w_div_zero ? 32'd1 : bus.b;
    assign w_quo_s    = $signed(bus.a) / w_div_b_s;
    assign w_rem_s    = $signed(bus.a) % w_div_b_s;
    assign w_quo_u    = bus.a / w_div_b_u;
    assign w_rem_u    = bus.a % w_div_b_u;

    // Next-state: launch, countdown/commit, cancel and direct HI/LO writes.
    always_comb begin
        w_cnt_nx     = r_cnt;
        w_hi_nx      = r_hi;
        w_lo_nx      = r_lo;
        w_pend_hi_nx = r_pend_hi;
        w_pend_lo_nx = r_pend_lo;
        w_pend_wr_nx = r_pend_wr;
        if (w_cancel) begin
            w_cnt_nx = 8'd0;
        end else if (w_launch) begin
            case (bus.mdu_op)
                OP_MULT: begin
                    w_cnt_nx                     = MULT_N;
                    {w_pend_hi_nx, w_pend_lo_nx} = w_mul_s;
                    w_pend_wr_nx                 = 1'b1;
                end
                OP_MULTU: begin
                    w_cnt_nx                     = MULT_N;
                    {w_pend_hi_nx, w_pend_lo_nx} = w_mul_u;
                    w_pend_wr_nx                 = 1'b1;
                end
                OP_DIV: begin
                    w_cnt_nx     = DIV_N;
                    w_pend_hi_nx = w_rem_s;
                    w_pend_lo_nx = w_quo_s;
                    w_pend_wr_nx = !w_div_zero;
                end
                OP_DIVU: begin
                    w_cnt_nx     = DIV_N;
                    w_pend_hi_nx = w_rem_u;
                    w_pend_lo_nx = w_quo_u;
                    w_pend_wr_nx = !w_div_zero;
                end
                default: w_cnt_nx = r_cnt;
            endcase
        end else if (r_cnt != 8'd0) begin
            w_cnt_nx = r_cnt - 8'd1;
            if ((r_cnt == 8'd1) && r_pend_wr) begin
                w_hi_nx = r_pend_hi;
                w_lo_nx = r_pend_lo;
            end else begin
                w_hi_nx = r_hi;
                w_lo_nx = r_lo;
            end
        end else begin
            w_cnt_nx = r_cnt;
        end

        // Idle implies the countdown branch above did not commit this edge.
        if (!r_busy && (bus.mdu_op == OP_MTHI)) begin
            w_hi_nx = bus.a;
        end else if (!r_busy && (bus.mdu_op == OP_MTLO)) begin
            w_lo_nx = bus.a;
        end else begin
        end
    end

    // Move-from read port, no latency.
    always_comb begin
        w_out = 32'd0;
        case (bus.mdu_op)
            OP_MFHI: w_out = r_hi;
            OP_MFLO: w_out = r_lo;
            default: w_out = 32'd0;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 8'd0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nx;
            r_busy    <= (w_cnt_nx != 8'd0);
            r_hi      <= w_hi_nx;
            r_lo      <= w_lo_nx;
            r_pend_hi <= w_pend_hi_nx;
            r_pend_lo <= w_pend_lo_nx;
            r_pend_wr <= w_pend_wr_nx;
        end
    end

    assign bus.busy = r_busy;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.out  = w_out;
endmodule

// File: tb/tb_mdu_unit.sv
// Randomized self-checking bench for mdu_unit against an arithmetic reference model.
// Exercises the MDU_CANCEL_EN feature when that macro is defined.
module tb_mdu_unit;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    mdu_unit_if bus_if();

    mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

`ifdef MDU_CANCEL_EN
    wire w_cancel = bus_if.cancel;
`else
    wire w_cancel = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {valid, hi, lo} from plain arithmetic.
    function automatic logic [64:0] ref_result(input logic [3:0] op, input logic [31:0] x,
                                               input logic [31:0] y);
        int              sx, sy;
        longint          ps;
        longint unsigned pu;
        logic [31:0]     ax, ay, q, r;
        sx = x;
        sy = y;
        case (op)
            4'd1: begin
                ps = longint'(sx) * longint'(sy);
                return {1'b1, ps[63:0]};
            end
            4'd2: begin
                pu = 64'(x) * 64'(y);
                return {1'b1, pu[63:0]};
            end
            4'd3: begin
                if (y == 32'd0) return {1'b0, 64'd0};
                ax = x[31] ? (32'd0 - x) : x;
                ay = y[31] ? (32'd0 - y) : y;
                q  = ax / ay;
                r  = ax % ay;
                if (x[31] ^ y[31]) q = 32'd0 - q;
                if (x[31]) r = 32'd0 - r;
                return {1'b1, r, q};
            end
            4'd4: begin
                if (y == 32'd0) return {1'b0, 64'd0};
                return {1'b1, x % y, x / y};
            end
            default: return {1'b0, 64'd0};
        endcase
    endfunction

    logic [31:0] m_hi, m_lo, m_ph, m_pl;
    logic        m_pv;
    int          m_left;

    // Reference model: busy cycles remaining plus the pending result.
    always @(posedge clk or negedge rst_n) begin
        logic [64:0] res;
        if (!rst_n) begin
            m_hi <= 32'd0; m_lo <= 32'd0; m_ph <= 32'd0; m_pl <= 32'd0;
            m_pv <= 1'b0;  m_left <= 0;
        end else begin
            if (w_cancel) begin
                m_left <= 0;
            end else if (bus_if.start && m_left == 0 && bus_if.mdu_op >= 4'd1 && bus_if.mdu_op <= 4'd4) begin
                res    = ref_result(bus_if.mdu_op, bus_if.a, bus_if.b);
                m_left <= (bus_if.mdu_op <= 4'd2) ? MULT_N : DIV_N;
                m_pv   <= res[64];
                m_ph   <= res[63:32];
                m_pl   <= res[31:0];
            end else if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1 && m_pv) begin
                    m_hi <= m_ph;
                    m_lo <= m_pl;
                end
            end
            if (m_left == 0 && bus_if.mdu_op == 4'd7) m_hi <= bus_if.a;
            if (m_left == 0 && bus_if.mdu_op == 4'd8) m_lo <= bus_if.a;
        end
    end

    // Compare DUT against the model mid-cycle.
    always @(negedge clk) begin
        logic [31:0] exp_out;
        exp_out = (bus_if.mdu_op == 4'd5) ? m_hi : (bus_if.mdu_op == 4'd6) ? m_lo : 32'd0;
        check("busy", {31'd0, bus_if.busy}, {31'd0, m_left != 0});
        check("hi", bus_if.hi, m_hi);
        check("lo", bus_if.lo, m_lo);
        check("out", bus_if.out, exp_out);
    end

    task automatic drive(input logic st, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk); #1;
        bus_if.start = st; bus_if.mdu_op = op; bus_if.a = x; bus_if.b = y;
    endtask

    // Launch one op, then count busy cycles until it drops (bounded).
    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, output int n);
        drive(1'b1, op, x, y);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        n = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus_if.busy) n++;
            else break;
        end
    endtask

    initial begin
        int n;
        logic [31:0] ra, rb;
        bus_if.start = 1'b0; bus_if.mdu_op = 4'd5; bus_if.a = 32'd0; bus_if.b = 32'd0;
`ifdef MDU_CANCEL_EN
        bus_if.cancel = 1'b0;
`endif
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check("rst_hi", bus_if.hi, 32'd0);
        check("rst_lo", bus_if.lo, 32'd0);
        check("rst_out", bus_if.out, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("mfhi_after_rst", bus_if.out, 32'd0);

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, n);
        check("mult_cycles", n, MULT_N);
        check("mult_hi", bus_if.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus_if.lo, 32'hFFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, n);
        check("multu_hi", bus_if.hi, 32'h0000_0002);
        check("multu_lo", bus_if.lo, 32'hFFFF_FFFA);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, n);
        check("div_cycles", n, DIV_N);
        check("div_lo", bus_if.lo, 32'hFFFF_FFFD);
        check("div_hi", bus_if.hi, 32'hFFFF_FFFF);
        run_op(4'd4, 32'd7, 32'd2, n);
        check("divu_lo", bus_if.lo, 32'd3);
        check("divu_hi", bus_if.hi, 32'd1);

        drive(1'b1, 4'd7, 32'h1234_5678, 32'd0);
        drive(1'b1, 4'd8, 32'h9ABC_DEF0, 32'd0);
        drive(1'b0, 4'd5, 32'd0, 32'd0);
        @(negedge clk);
        check("mfhi_out", bus_if.out, 32'h1234_5678);
        run_op(4'd3, 32'd55, 32'd0, n);
        check("div0_cycles", n, DIV_N);
        check("div0_hi", bus_if.hi, 32'h1234_5678);
        check("div0_lo", bus_if.lo, 32'h9ABC_DEF0);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        check("ovf_lo", bus_if.lo, 32'h8000_0000);
        check("ovf_hi", bus_if.hi, 32'd0);

        // Reset in the fourth busy cycle of a DIV.
        drive(1'b1, 4'd3, 32'd100, 32'd7);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, bus_if.busy}, 32'd0);
        check("midrst_hi", bus_if.hi, 32'd0);
        check("midrst_lo", bus_if.lo, 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        run_op(4'd1, 32'd6, 32'd7, n);
        check("post_rst_cycles", n, MULT_N);
        check("post_rst_lo", bus_if.lo, 32'd42);

`ifdef MDU_CANCEL_EN
        drive(1'b1, 4'd1, 32'd3, 32'd3);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        #2 bus_if.cancel = 1'b1;
        @(posedge clk); #1 bus_if.cancel = 1'b0;
        @(negedge clk);
        check("cancel_busy", {31'd0, bus_if.busy}, 32'd0);
        check("cancel_lo", bus_if.lo, 32'd42);
        @(posedge clk); #1;
        bus_if.cancel = 1'b1; bus_if.start = 1'b1; bus_if.mdu_op = 4'd1; bus_if.a = 32'd2; bus_if.b = 32'd2;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        bus_if.cancel = 1'b0;
        @(negedge clk);
        check("cancel_start_busy", {31'd0, bus_if.busy}, 32'd0);
`endif

        // Random traffic, including illegal ops and starts while busy.
        for (int i = 0; i < 3000; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            drive(($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), ra, rb);
`ifdef MDU_CANCEL_EN
            bus_if.cancel = ($urandom_range(0, 40) == 0);
`endif
        end
        drive(1'b0, 4'd0, 32'd0, 32'd0);
`ifdef MDU_CANCEL_EN
        bus_if.cancel = 1'b0;
`endif
        repeat (15) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
